// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage.
// Multi-cycle MULT/DIV with busy/done handshake, single-cycle MTHI/MTLO.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MDRdSel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDOut
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               load;
    logic               mt_hi;
    logic               mt_lo;
    logic               finish;

    logic               is_div;
    logic               is_sdiv;
    logic               is_smul;
    logic               wr_en;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, dvsr;
    logic [WIDTH-1:0]   uq, ur, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = MDRdSel ? hi_q : lo_q;

    // Next-state and control: accept ops in IDLE, count down in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDOp)
                        OP_MULT, OP_MULTU: begin
                            load    = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            load    = 1'b1;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Arithmetic on the latched operands; only sampled when finish is high.
    always_comb begin
        is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
        is_sdiv = (op_q == OP_DIV);
        is_smul = (op_q == OP_MULT);

        ext_a = is_smul ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                        : {{WIDTH{1'b0}}, a_q};
        ext_b = is_smul ? {{WIDTH{b_q[WIDTH-1]}}, b_q}
                        : {{WIDTH{1'b0}}, b_q};
        prod  = ext_a * ext_b;

        // Signed divide via magnitudes; MIN / -1 falls out as MIN, rem 0.
        a_neg = is_sdiv && a_q[WIDTH-1];
        b_neg = is_sdiv && b_q[WIDTH-1];
        mag_a = a_neg ? -a_q : a_q;
        mag_b = b_neg ? -b_q : b_q;
        dvsr  = (mag_b == '0) ? WIDTH'(1) : mag_b;
        uq    = mag_a / dvsr;
        ur    = mag_a % dvsr;
        quo   = (a_neg ^ b_neg) ? -uq : uq;
        rem   = a_neg ? -ur : ur;

        res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? quo : prod[WIDTH-1:0];

        // Divide by zero runs full latency but leaves HI/LO alone.
        wr_en = finish && !(is_div && (b_q == '0));
    end

    // State, counter and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= finish;
        end
    end

    // Operand latch and HI/LO register updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (load) begin
                op_q <= MDOp;
                a_q  <= A;
                b_q  <= B;
            end
            if (mt_hi) hi_q <= A;
            if (mt_lo) lo_q <= A;
            if (wr_en) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

endmodule
